// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-arbiter FSM state encoding.
package regfile_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, modulo NREQ.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_valid,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any
);

    logic [PTR_W:0]   sum_s;
    logic [PTR_W-1:0] pos_s;
    logic             hit_s;

    // Walk the requesters starting at rr_ptr; the first valid one takes the grant.
    always_comb begin
        grant     = {NREQ{1'b0}};
        grant_idx = {PTR_W{1'b0}};
        any       = 1'b0;
        sum_s     = {(PTR_W+1){1'b0}};
        pos_s     = {PTR_W{1'b0}};
        hit_s     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            pos_s = (sum_s >= (PTR_W+1)'(NREQ)) ? PTR_W'(sum_s - (PTR_W+1)'(NREQ))
                                                : PTR_W'(sum_s);
            hit_s = !any && req_valid[pos_s];
            grant[pos_s] = grant[pos_s] | hit_s;
            grant_idx    = hit_s ? pos_s : grant_idx;
            any          = any | hit_s;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port arbiter for the 32x32 register file with register-0 write suppression.
// Optional bulk clear of registers 1..31 is compiled in when REGFILE_ARB_CLEAR_EN is defined.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clock,
    input  logic                     ctrl_reset_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     clr_start,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     busy,
    output logic                     clr_done
);

    localparam int PTR_W = $clog2(NREQ);

    logic [NREQ-1:0]   grant_s;
    logic [PTR_W-1:0]  grant_idx_s;
    logic              any_s;
    logic              grant_en_s;
    logic              accept_s;
    logic              clear_act_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [PTR_W-1:0]  rr_ptr_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;

    rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any       (any_s)
    );

`ifdef REGFILE_ARB_CLEAR_EN
    localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(REG_COUNT - 1);

    arb_state_e            state_r;
    arb_state_e            state_nxt_s;
    logic [REG_ADDR_W-1:0] cnt_r;
    logic                  last_s;
    logic                  clr_done_r;

    assign last_s = (cnt_r == LAST_REG);

    // Next-state logic: a clear request in IDLE wins over requesters.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = clr_start ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: state_nxt_s = last_s ? ST_IDLE : ST_CLEAR;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Clear address counter; it stops at the last register instead of wrapping.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            cnt_r <= 5'd0;
        end else if (state_r == ST_IDLE && clr_start) begin
            cnt_r <= 5'd1;
        end else if (state_r == ST_CLEAR && !last_s) begin
            cnt_r <= cnt_r + 5'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Completion pulse travels with the write to the last register.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            clr_done_r <= 1'b0;
        end else begin
            clr_done_r <= (state_r == ST_CLEAR) && last_s;
        end
    end

    assign grant_en_s  = (state_r == ST_IDLE) && !clr_start;
    assign clear_act_s = (state_r == ST_CLEAR);
    assign clr_addr_s  = ADDR_W'(cnt_r);
    assign busy        = clear_act_s;
    assign clr_done    = clr_done_r;
`else
    logic unused_clr_s;

    assign unused_clr_s = clr_start;
    assign grant_en_s   = 1'b1;
    assign clear_act_s  = 1'b0;
    assign clr_addr_s   = {ADDR_W{1'b0}};
    assign busy         = 1'b0;
    assign clr_done     = 1'b0;
`endif

    assign req_ready = grant_en_s ? grant_s : {NREQ{1'b0}};
    assign accept_s  = grant_en_s && any_s;

    // One-hot mux of the granted requester's address and data.
    always_comb begin
        sel_addr_s = {ADDR_W{1'b0}};
        sel_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            sel_addr_s = sel_addr_s | ({ADDR_W{grant_s[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
            sel_data_s = sel_data_s | ({DATA_W{grant_s[i]}} & req_data[i*DATA_W +: DATA_W]);
        end
    end

    // Round-robin pointer moves just past the requester that was accepted.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            rr_ptr_r <= {PTR_W{1'b0}};
        end else if (accept_s) begin
            rr_ptr_r <= (grant_idx_s == PTR_W'(NREQ - 1)) ? {PTR_W{1'b0}}
                                                          : grant_idx_s + PTR_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Registered write port; address 0 completes the handshake but never writes.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {DATA_W{1'b0}};
        end else if (clear_act_s) begin
            wr_en_r   <= 1'b1;
            wr_addr_r <= clr_addr_s;
            wr_data_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            wr_en_r   <= (sel_addr_s != ADDR_W'(ZERO_REG));
            wr_addr_r <= sel_addr_s;
            wr_data_r <= sel_data_s;
        end else begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= wr_addr_r;
            wr_data_r <= wr_data_r;
        end
    end

    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter; clear scenarios run when REGFILE_ARB_CLEAR_EN is defined.
module tb_regfile_wr_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              done;
    } wr_t;

    logic                   clock = 1'b0;
    logic                   ctrl_reset_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   clr_start;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   busy;
    logic                   clr_done;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    regfile_wr_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .clr_start    (clr_start),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .clr_done     (clr_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    // Drive valids at posedge+1, check ready/busy at negedge, queue the expected write.
    task automatic step(input string name, input logic [NREQ-1:0] v,
                        input logic [NREQ-1:0] exp_rdy, input logic exp_busy);
        wr_t e;
        req_valid = v;
        @(negedge clock);
        chk({name, "_ready"}, 64'(req_ready), 64'(exp_rdy));
        chk({name, "_busy"}, 64'(busy), 64'(exp_busy));
        for (int i = 0; i < NREQ; i++) begin
            if (exp_rdy[i] && req_addr[i*ADDR_W +: ADDR_W] != 5'd0) begin
                e.addr = req_addr[i*ADDR_W +: ADDR_W];
                e.data = req_data[i*DATA_W +: DATA_W];
                e.done = 1'b0;
                exp_q.push_back(e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    // Monitor: every presented write is popped from the scoreboard and compared.
    always @(negedge clock) begin
        wr_t e;
        if (ctrl_reset_n) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=%0h expected no write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("write", 64'({wr_addr, wr_data, clr_done}), 64'({e.addr, e.data, e.done}));
                end
            end else if (clr_done) begin
                checks++;
                errors++;
                $display("FAIL stray_clr_done: got 1 expected 0");
            end
        end
    end

    initial begin
        wr_t e;
        logic [NREQ-1:0] rr_order [4];
        rr_order[0] = 4'b0001;
        rr_order[1] = 4'b0010;
        rr_order[2] = 4'b0100;
        rr_order[3] = 4'b1000;

        ctrl_reset_n = 1'b0;
        req_valid    = 4'b0000;
        req_addr     = '0;
        req_data     = '0;
        clr_start    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_clr_done", 64'(clr_done), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        ctrl_reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Single write from requester 1.
        set_req(1, 5'd7, 32'hDEADBEEF);
        step("single", 4'b0010, 4'b0010, 1'b0);
        chk("single_t1_wr_en", 64'(wr_en), 64'd1);
        chk("single_t1_wr_addr", 64'(wr_addr), 64'd7);
        chk("single_t1_wr_data", 64'(wr_data), 64'hDEADBEEF);
        step("single_idle", 4'b0000, 4'b0000, 1'b0);
        chk("single_t2_wr_en", 64'(wr_en), 64'd0);

        // Mid-run reset while a write is on the port (pointer is 2 here).
        set_req(0, 5'd8, 32'hA0A0_0000);
        set_req(1, 5'd9, 32'hB1B1_1111);
        set_req(2, 5'd10, 32'hC2C2_2222);
        set_req(3, 5'd11, 32'hD3D3_3333);
        step("pre_rst", 4'b1111, 4'b0100, 1'b0);
        req_valid = 4'b0000;
        chk("pre_rst_wr_en", 64'(wr_en), 64'd1);
        ctrl_reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_wr_en", 64'(wr_en), 64'd0);
        chk("async_rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("async_rst_wr_data", 64'(wr_data), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        ctrl_reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Round robin from a fresh pointer: 0,1,2,3,0,1,2,3.
        for (int c = 0; c < 8; c++) begin
            step($sformatf("rr%0d", c), 4'b1111, rr_order[c % 4], 1'b0);
        end
        req_valid = 4'b0000;

        // Register 0 target: handshake completes, no write, next grant to requester 3.
        set_req(2, 5'd0, 32'h5555_5555);
        step("reg0", 4'b0100, 4'b0100, 1'b0);
        chk("reg0_no_wr", 64'(wr_en), 64'd0);
        step("after_reg0", 4'b1011, 4'b1000, 1'b0);
        req_valid = 4'b0000;
        set_req(2, 5'd10, 32'hC2C2_2222);

`ifdef REGFILE_ARB_CLEAR_EN
        // Clear colliding with all requesters; pointer is 0.
        clr_start = 1'b1;
        step("clr_t0", 4'b1111, 4'b0000, 1'b0);
        clr_start = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            e.addr = ADDR_W'(k);
            e.data = 32'h0000_0000;
            e.done = (k == 31);
            exp_q.push_back(e);
        end
        for (int k = 1; k <= 31; k++) begin
            step($sformatf("clr_t%0d", k), 4'b1111, 4'b0000, 1'b1);
        end
        step("clr_t32", 4'b1111, 4'b0001, 1'b0);
        req_valid = 4'b0000;

        // Reset during a clear aborts it with no clr_done.
        clr_start = 1'b1;
        step("abort_t0", 4'b0000, 4'b0000, 1'b0);
        clr_start = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            e.addr = ADDR_W'(k);
            e.data = 32'h0000_0000;
            e.done = (k == 31);
            exp_q.push_back(e);
        end
        for (int k = 1; k <= 3; k++) begin
            step($sformatf("abort_t%0d", k), 4'b0000, 4'b0000, 1'b1);
        end
        ctrl_reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_wr_en", 64'(wr_en), 64'd0);
        chk("abort_clr_done", 64'(clr_done), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        ctrl_reset_n = 1'b1;
        repeat (35) @(posedge clock);
        #1;
        step("post_abort", 4'b1111, 4'b0001, 1'b0);
        req_valid = 4'b0000;
`else
        // Clear request is ignored: requester 1 granted in the same cycle.
        clr_start = 1'b1;
        step("noclr", 4'b0010, 4'b0010, 1'b0);
        clr_start = 1'b0;
        chk("noclr_clr_done", 64'(clr_done), 64'd0);
        chk("noclr_busy", 64'(busy), 64'd0);
        req_valid = 4'b0000;
`endif

        repeat (2) @(posedge clock);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
